jttrack_dwnld_ctrl: RTL and testbench

//  Download front-end for the Track'n'Field core. Turns the ioctl byte stream into SDRAM

---
 rtl/jttrack_dwnld_ctrl.sv | 147 ++++++++++++++
 tb/tb_jttrack_dwnld_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jttrack_dwnld_ctrl.sv
// Track'n'Field download front-end: ioctl bytes to SDRAM writes (via a small FIFO) and PROM writes.
// Optional JTTRACK_DWNLD_CHKSUM_EN adds a 16-bit running byte sum output.
module jttrack_dwnld_ctrl #(
    parameter logic [21:0] SCR_START  = 22'h0,
    parameter logic [21:0] OBJ_START  = 22'h0,
    parameter logic [21:0] PCM_START  = 22'h0,
    parameter logic [24:0] PROM_START = 25'h0,
    parameter int          FIFO_AW    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        ioctl_wr,
    output logic [21:0] prog_addr,
    output logic [7:0]  prog_data,
    output logic [1:0]  prog_mask,
    output logic        prog_we,
    input  logic        sdram_ack,
    output logic [10:0] prom_addr,
    output logic [7:0]  prom_data,
    output logic        prom_we,
    output logic        is_hyper,
    output logic        dwnld_busy,
`ifdef JTTRACK_DWNLD_CHKSUM_EN
    output logic [15:0] chksum,
`endif
    output logic        ovf
);

    localparam int               DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] CNT_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    logic        capture, in_prom, in_obj, push, pop, push_ok, empty, full;
    logic        dl_prev, dl_rise;
    logic [21:0] raw_waddr, push_waddr;
    logic [10:0] prom_offset;
    logic [1:0]  state;

    logic [30:0]        mem [DEPTH];
    logic [30:0]        head;
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;

    assign capture     = ioctl_wr & downloading;
    assign in_prom     = ioctl_addr >= PROM_START;
    assign in_obj      = (ioctl_addr >= {3'b0, OBJ_START}) && (ioctl_addr < {3'b0, PCM_START});
    assign raw_waddr   = ioctl_addr[22:1];
    // OBJ ROM words are stored with their low address lines rotated and partly inverted
    assign push_waddr  = in_obj ? {raw_waddr[21:5], raw_waddr[2:0], ~raw_waddr[4], ~raw_waddr[3]}
                                : raw_waddr;
    assign prom_offset = ioctl_addr[10:0] - PROM_START[10:0];

    assign empty   = count == '0;
    assign full    = count == FULL_CNT;
    assign push    = capture & ~in_prom;
    assign pop     = (state == WRITE) & sdram_ack;
    assign push_ok = push & (~full | pop);
    assign head    = mem[rd_ptr];
    assign dl_rise = downloading & ~dl_prev;

    assign dwnld_busy = downloading | ~empty;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {push_waddr, ioctl_dout, ioctl_addr[0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
            if (push_ok && !pop)      count <= count + CNT_ONE;
            else if (!push_ok && pop) count <= count - CNT_ONE;
            if (push && full && !pop) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prog_we   <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
            prog_mask <= '0;
        end else begin
            case (state)
                IDLE: if (!empty) begin
                    state     <= WRITE;
                    prog_we   <= 1'b1;
                    prog_addr <= head[30:9];
                    prog_data <= head[8:1];
                    prog_mask <= head[0] ? 2'b10 : 2'b01;
                end
                WRITE: if (sdram_ack) begin
                    state   <= GAP;
                    prog_we <= 1'b0;
                end
                GAP: state <= IDLE;
                default: begin
                    state   <= IDLE;
                    prog_we <= 1'b0;
                end
            endcase
        end
    end

    // PROM bytes bypass the FIFO; the header byte at PROM_START+1 flags Hyper Sports
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prom_we   <= 1'b0;
            prom_addr <= '0;
            prom_data <= '0;
            is_hyper  <= 1'b0;
            dl_prev   <= 1'b0;
        end else begin
            dl_prev <= downloading;
            prom_we <= capture & in_prom;
            if (capture && in_prom) begin
                prom_addr <= prom_offset;
                prom_data <= ioctl_dout;
            end
            if (capture && ioctl_addr == PROM_START + 25'd1) is_hyper <= &ioctl_dout;
            else if (dl_rise)                                 is_hyper <= 1'b0;
        end
    end

`ifdef JTTRACK_DWNLD_CHKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       chksum <= '0;
        else if (dl_rise) chksum <= capture ? {8'h0, ioctl_dout} : 16'h0;
        else if (capture) chksum <= chksum + {8'h0, ioctl_dout};
    end
`endif

endmodule

// File: tb/tb_jttrack_dwnld_ctrl.sv
// Scoreboard bench for jttrack_dwnld_ctrl: stimulus queues expected SDRAM/PROM writes, a monitor checks them.
module tb_jttrack_dwnld_ctrl;

    localparam logic [21:0] SCR  = 22'h0;
    localparam logic [21:0] OBJ  = 22'h10000;
    localparam logic [21:0] PCM  = 22'h20000;
    localparam logic [24:0] PROM = 25'h40000;

    typedef struct packed {
        logic [21:0] a;
        logic [7:0]  d;
        logic [1:0]  m;
    } wr_t;

    typedef struct packed {
        logic [10:0] a;
        logic [7:0]  d;
    } pr_t;

    logic        clk, rst_n, downloading, ioctl_wr, sdram_ack;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout, prog_data, prom_data;
    logic [21:0] prog_addr;
    logic [1:0]  prog_mask;
    logic        prog_we, prom_we, is_hyper, dwnld_busy, ovf;
    logic [10:0] prom_addr;
`ifdef JTTRACK_DWNLD_CHKSUM_EN
    logic [15:0] chksum;
`endif

    wr_t         prog_q[$];
    pr_t         prom_q[$];
    int          checks = 0;
    int          failures = 0;
    int          ack_mode = 2;
    logic        hyper_model = 1'b0;
    logic [15:0] sum_model = 16'h0;

    jttrack_dwnld_ctrl #(
        .SCR_START(SCR), .OBJ_START(OBJ), .PCM_START(PCM), .PROM_START(PROM), .FIFO_AW(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
        .prog_we(prog_we), .sdram_ack(sdram_ack),
        .prom_addr(prom_addr), .prom_data(prom_data), .prom_we(prom_we),
        .is_hyper(is_hyper), .dwnld_busy(dwnld_busy),
`ifdef JTTRACK_DWNLD_CHKSUM_EN
        .chksum(chksum),
`endif
        .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Word address from the address-map rules: byte address halved, OBJ region low lines remapped
    function automatic logic [21:0] modelWaddr(input logic [24:0] addr);
        int unsigned w, lo, b3, b4;
        w = (32'(addr) / 2) % (1 << 22);
        if (32'(addr) >= 32'(OBJ) && 32'(addr) < 32'(PCM)) begin
            lo = w % 32;
            b3 = (lo / 8) % 2;
            b4 = (lo / 16) % 2;
            w  = w - lo + (lo % 8) * 4 + (1 - b4) * 2 + (1 - b3);
        end
        return w[21:0];
    endfunction

    task automatic applyStimulus(input logic [24:0] addr, input logic [7:0] data,
                                 input bit hold, input bit drop);
        wr_t e;
        pr_t p;
        @(posedge clk); #1;
        ioctl_addr = addr;
        ioctl_dout = data;
        ioctl_wr   = 1'b1;
        if (downloading) begin
            sum_model = sum_model + 16'(data);
            if (addr >= PROM) begin
                p.a = 11'((addr - PROM) % 2048);
                p.d = data;
                prom_q.push_back(p);
                if (32'(addr) == 32'(PROM) + 1) hyper_model = (data == 8'hFF);
            end else if (!drop) begin
                e.a = modelWaddr(addr);
                e.d = data;
                e.m = addr[0] ? 2'b10 : 2'b01;
                prog_q.push_back(e);
            end
        end
        if (!hold) begin
            @(posedge clk); #1;
            ioctl_wr = 1'b0;
        end
    endtask

    task automatic setDownload(input logic v);
        @(posedge clk); #1;
        if (v && !downloading) begin
            hyper_model = 1'b0;
            sum_model   = 16'h0;
        end
        downloading = v;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((prog_q.size() != 0 || prom_q.size() != 0) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 2000) checkOutput("drain_timeout", 32'(prog_q.size() + prom_q.size()), 0);
    endtask

    initial begin
        sdram_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ack_mode)
                0:       sdram_ack = 1'($urandom_range(0, 1));
                1:       sdram_ack = 1'b1;
                default: sdram_ack = 1'b0;
            endcase
        end
    end

    // Monitor: completed writes against the scoreboard, plus hold/gap rules of the handshake
    initial begin
        logic        prev_we = 1'b0;
        logic        prev_ack = 1'b0;
        logic [31:0] prev_vec = '0;
        wr_t         e;
        pr_t         p;
        forever begin
            @(negedge clk);
            if (prog_we) begin
                if (prev_we && !prev_ack)
                    checkOutput("prog_hold", {prog_addr, prog_data, prog_mask}, prev_vec);
                if (prev_we && prev_ack)
                    checkOutput("gap_after_ack", 32'(prog_we), 0);
                if (sdram_ack) begin
                    if (prog_q.size() == 0) begin
                        checkOutput("unexpected_write", {prog_addr, prog_data, prog_mask}, 0);
                    end else begin
                        e = prog_q.pop_front();
                        checkOutput("prog_write", {prog_addr, prog_data, prog_mask}, e);
                    end
                end
            end
            if (prom_we) begin
                if (prom_q.size() == 0) begin
                    checkOutput("unexpected_prom", 32'({prom_addr, prom_data}), 0);
                end else begin
                    p = prom_q.pop_front();
                    checkOutput("prom_write", 32'({prom_addr, prom_data}), 32'(p));
                end
            end
            prev_we  = prog_we;
            prev_ack = sdram_ack;
            prev_vec = {prog_addr, prog_data, prog_mask};
        end
    end

    initial begin
        logic [24:0] bound_addrs [6];
        logic [24:0] a;
        int          cls, guard;

        rst_n       = 1'b0;
        downloading = 1'b0;
        ioctl_wr    = 1'b0;
        ioctl_addr  = '0;
        ioctl_dout  = '0;
        #23;
        checkOutput("rst_prog_we", 32'(prog_we), 0);
        checkOutput("rst_prog_addr", 32'(prog_addr), 0);
        checkOutput("rst_prom_we", 32'(prom_we), 0);
        checkOutput("rst_is_hyper", 32'(is_hyper), 0);
        checkOutput("rst_busy", 32'(dwnld_busy), 0);
        checkOutput("rst_ovf", 32'(ovf), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Strobes without downloading must leave no trace
        ack_mode = 1;
        applyStimulus(25'h100, 8'h12, 0, 0);
        applyStimulus(PROM + 25'd1, 8'hFF, 0, 0);
        repeat (4) @(posedge clk);
        #1 checkOutput("ignored_hyper", 32'(is_hyper), 0);
        checkOutput("ignored_busy", 32'(dwnld_busy), 0);

        setDownload(1);
        applyStimulus(25'h10, 8'hAA, 0, 0);
        applyStimulus(25'h11, 8'h55, 0, 0);
        bound_addrs[0] = 25'h0FFFF;
        bound_addrs[1] = 25'h10000;
        bound_addrs[2] = 25'h10006;
        bound_addrs[3] = 25'h1FFFF;
        bound_addrs[4] = 25'h20000;
        bound_addrs[5] = 25'h3FFFF;
        foreach (bound_addrs[i]) applyStimulus(bound_addrs[i], 8'($urandom), 0, 0);
        applyStimulus(PROM + 25'd1, 8'h7E, 0, 0);
        checkOutput("hyper_not_ff", 32'(is_hyper), 0);
        applyStimulus(PROM, 8'($urandom), 0, 0);
        applyStimulus(PROM + 25'd1, 8'hFF, 0, 0);
        checkOutput("hyper_set", 32'(is_hyper), 1);
        applyStimulus(PROM + 25'h7FF, 8'($urandom), 0, 0);
        waitDrain();

        ack_mode = 0;
        for (int i = 0; i < 80; i++) begin
            guard = 0;
            while (prog_q.size() > 2 && guard < 500) begin
                @(posedge clk);
                guard++;
            end
            if (guard >= 500) checkOutput("space_timeout", 32'(prog_q.size()), 2);
            cls = $urandom_range(0, 3);
            case (cls)
                0:       a = 25'($urandom_range(0, 32'hFFFF));
                1:       a = 25'($urandom_range(32'h10000, 32'h1FFFF));
                2:       a = 25'($urandom_range(32'h20000, 32'h3FFFF));
                default: a = PROM + 25'($urandom_range(0, 4095));
            endcase
            applyStimulus(a, 8'($urandom), 0, 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        waitDrain();
        @(posedge clk); #1;
        checkOutput("rand_hyper", 32'(is_hyper), 32'(hyper_model));
        checkOutput("busy_while_dl", 32'(dwnld_busy), 1);
`ifdef JTTRACK_DWNLD_CHKSUM_EN
        checkOutput("rand_chksum", 32'(chksum), 32'(sum_model));
`endif

        // New download clears the Hyper flag and the checksum
        ack_mode = 1;
        applyStimulus(PROM + 25'd1, 8'hFF, 0, 0);
        checkOutput("hyper_again", 32'(is_hyper), 1);
        setDownload(0);
        setDownload(1);
        repeat (2) @(posedge clk);
        #1 checkOutput("hyper_cleared", 32'(is_hyper), 0);
        applyStimulus(25'h20, 8'h01, 0, 0);
        applyStimulus(25'h21, 8'hFF, 0, 0);
        applyStimulus(25'h22, 8'h80, 0, 0);
        waitDrain();
`ifdef JTTRACK_DWNLD_CHKSUM_EN
        @(posedge clk); #1;
        checkOutput("chksum_0180", 32'(chksum), 32'h0180);
`endif

        // Overflow: ack held low, five back-to-back strobes into a four-entry FIFO
        ack_mode = 2;
        repeat (3) @(posedge clk);
        #1 checkOutput("ovf_before", 32'(ovf), 0);
        for (int i = 0; i < 5; i++)
            applyStimulus(25'h100 + 25'(i), 8'(8'hC0 + i), i != 4, i == 4);
        checkOutput("ovf_set", 32'(ovf), 1);
        setDownload(0);
        #1 checkOutput("busy_pending", 32'(dwnld_busy), 1);
        ack_mode = 1;
        waitDrain();
        repeat (3) @(posedge clk);
        #1 checkOutput("busy_drained", 32'(dwnld_busy), 0);
        checkOutput("ovf_sticky", 32'(ovf), 1);

        // Reset in the middle of a held write with three entries queued
        setDownload(1);
        ack_mode = 2;
        applyStimulus(25'h200, 8'h11, 0, 0);
        applyStimulus(25'h202, 8'h22, 0, 0);
        applyStimulus(25'h204, 8'h33, 0, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("midrst_prog_we", 32'(prog_we), 0);
        checkOutput("midrst_busy", 32'(dwnld_busy), 1);
        checkOutput("midrst_ovf", 32'(ovf), 0);
        prog_q.delete();
        prom_q.delete();
        sum_model   = 16'h0;
        hyper_model = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ack_mode = 1;
        repeat (20) @(posedge clk);
        #1 checkOutput("postrst_prog_we", 32'(prog_we), 0);
        checkOutput("postrst_busy", 32'(dwnld_busy), 1);
        setDownload(0);
        #1 checkOutput("postrst_idle", 32'(dwnld_busy), 0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
